// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: FSM state encoding, mode-0 pad
// levels and the width of the shared bit/hold counter.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } spi_state_t;

    // Mode 0: s_clk idles low, sample on rise, launch after fall.
    localparam logic SCLK_IDLE   = 1'b0;
    localparam logic SAMPLE_RISE = 1'b1;
    localparam logic CS_ACTIVE   = 1'b0;
    localparam logic CS_IDLE     = 1'b1;

    // Wide enough for DATA_W (<= 32) falls and CLK_DIV-2 (<= 253) hold cycles.
    localparam int unsigned SPI_CNT_W = 8;

endpackage

// File: rtl/spi_clk_gen.sv
// Serial clock generator: divides clk by CLK_DIV per half-period while
// enabled, and flags the clk edge on which s_clk rises or falls.
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    output logic rise_stb,
    output logic fall_stb,
    output logic s_clk
);

    localparam int unsigned CW = $clog2(CLK_DIV + 1);

    logic [CW-1:0] cnt;
    logic          toggle;

    // The first enabled edge is the chip-select fall, so the counter runs
    // 1..CLK_DIV and the first toggle lands CLK_DIV edges after it.
    always_comb begin
        toggle   = en && (cnt == CW'(CLK_DIV));
        rise_stb = toggle && (s_clk == SCLK_IDLE);
        fall_stb = toggle && (s_clk != SCLK_IDLE);
    end

    // Divider counter and s_clk level; parked at idle whenever disabled.
    always_ff @(posedge clk) begin
        if (!reset_n || !en) begin
            cnt   <= '0;
            s_clk <= SCLK_IDLE;
        end else if (toggle) begin
            cnt   <= CW'(1);
            s_clk <= ~s_clk;
        end else begin
            cnt   <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master, one DATA_W-bit frame per handshake, MSB first.
// Optional SPI_MASTER_LOOPBACK_EN adds a loopback input that samples the
// internal mosi instead of the miso pad.
module spi_master
    import spi_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              s_clk,
    output logic              mosi,
    input  logic              miso,
    output logic              chip_sel
`ifdef SPI_MASTER_LOOPBACK_EN
    ,
    input  logic              loopback
`endif
);

    spi_state_t           state, state_nxt;
    logic [DATA_W-1:0]    tx_sh, rx_sh;
    logic [SPI_CNT_W-1:0] cnt;
    logic                 accept, last_fall, hold_done, clk_en;
    logic                 rise_stb, fall_stb, sample_bit;

    spi_clk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_gen (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (clk_en),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb),
        .s_clk    (s_clk)
    );

    // Handshake, frame/hold termination and next-state decode.
    always_comb begin
        tx_ready   = reset_n && (state == IDLE);
        busy       = (state != IDLE);
        accept     = tx_valid && tx_ready;
        clk_en     = (state == SHIFT);
        last_fall  = (state == SHIFT) && fall_stb && (cnt == SPI_CNT_W'(DATA_W - 1));
        hold_done  = (state == HOLD) && (cnt == SPI_CNT_W'(CLK_DIV - 2));
`ifdef SPI_MASTER_LOOPBACK_EN
        sample_bit = loopback ? mosi : miso;
`else
        sample_bit = miso;
`endif
        state_nxt  = state;
        case (state)
            IDLE:    if (accept)    state_nxt = SHIFT;
            SHIFT:   if (last_fall) state_nxt = HOLD;
            HOLD:    if (hold_done) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Shift registers, counter and registered pad outputs. Pads follow the
    // pre-edge state, so chip_sel/mosi appear one cycle after acceptance.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tx_sh    <= '0;
            rx_sh    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            mosi     <= 1'b0;
            chip_sel <= CS_IDLE;
            cnt      <= '0;
        end else begin
            rx_valid <= last_fall;
            chip_sel <= ((state == SHIFT) && !last_fall) ? CS_ACTIVE : CS_IDLE;
            case (state)
                IDLE: begin
                    cnt  <= '0;
                    mosi <= 1'b0;
                    if (accept) tx_sh <= tx_data;
                end
                SHIFT: begin
                    if (rise_stb == SAMPLE_RISE)
                        rx_sh <= {rx_sh[DATA_W-2:0], sample_bit};
                    if (fall_stb) begin
                        tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
                        cnt   <= cnt + SPI_CNT_W'(1);
                    end
                    if (last_fall) begin
                        cnt     <= '0;
                        rx_data <= rx_sh;
                        mosi    <= 1'b0;
                    end else begin
                        mosi <= fall_stb ? tx_sh[DATA_W-2] : tx_sh[DATA_W-1];
                    end
                end
                HOLD: begin
                    cnt  <= cnt + SPI_CNT_W'(1);
                    mosi <= 1'b0;
                end
                default: begin
                    cnt  <= '0;
                    mosi <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: an 8-bit/CLK_DIV=4 instance driven by a
// mode-0 slave model, and a 16-bit/CLK_DIV=2 instance with miso wired to mosi.
module tb_spi_master;

    localparam int DW_A = 8;
    localparam int CD_A = 4;
    localparam int DW_B = 16;
    localparam int CD_B = 2;

    logic clk = 1'b0;
    logic reset_n;

    logic [DW_A-1:0] tx_data_a, rx_data_a;
    logic tx_valid_a, tx_ready_a, rx_valid_a, busy_a, s_clk_a, mosi_a, miso_a, chip_sel_a;
    logic [DW_B-1:0] tx_data_b, rx_data_b;
    logic tx_valid_b, tx_ready_b, rx_valid_b, busy_b, s_clk_b, mosi_b, chip_sel_b;
`ifdef SPI_MASTER_LOOPBACK_EN
    logic lb_a = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] slave_sh = '0;
    logic [7:0] slave_word = '0;

    int cs_first, cs_last, n_rise, rise_err, rv_cnt, rv_cyc, rdy_cyc, cs_mosi_viol;
    logic [7:0] mosi_bits, rv_data;

    always #5 clk = ~clk;

    spi_master #(.DATA_W(DW_A), .CLK_DIV(CD_A)) dut_a (
        .clk(clk), .reset_n(reset_n), .tx_data(tx_data_a), .tx_valid(tx_valid_a),
        .tx_ready(tx_ready_a), .rx_data(rx_data_a), .rx_valid(rx_valid_a), .busy(busy_a),
        .s_clk(s_clk_a), .mosi(mosi_a), .miso(miso_a), .chip_sel(chip_sel_a)
`ifdef SPI_MASTER_LOOPBACK_EN
        , .loopback(lb_a)
`endif
    );

    spi_master #(.DATA_W(DW_B), .CLK_DIV(CD_B)) dut_b (
        .clk(clk), .reset_n(reset_n), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
        .tx_ready(tx_ready_b), .rx_data(rx_data_b), .rx_valid(rx_valid_b), .busy(busy_b),
        .s_clk(s_clk_b), .mosi(mosi_b), .miso(mosi_b), .chip_sel(chip_sel_b)
`ifdef SPI_MASTER_LOOPBACK_EN
        , .loopback(1'b0)
`endif
    );

    // Mode-0 slave: loads its word on select, shifts after each s_clk fall.
    always @(negedge chip_sel_a) slave_sh <= slave_word;
    always @(negedge s_clk_a) if (!chip_sel_a) slave_sh <= {slave_sh[6:0], 1'b0};
    assign miso_a = chip_sel_a ? 1'b0 : slave_sh[7];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready_a();
        int guard = 0;
        while (!tx_ready_a && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        check("ready_timeout_a", 32'(guard < 200), 32'd1);
    endtask

    // One frame on dut_a; cycle numbers are edges after the acceptance edge.
    task automatic run_frame(input logic [7:0] data, input logic [7:0] sword,
                             input int change_cyc, input int rst_cyc);
        logic prev_sclk;
        cs_first = -1; cs_last = -1; n_rise = 0; rise_err = 0; rv_cnt = 0;
        rv_cyc = -1; rdy_cyc = -1; cs_mosi_viol = 0; mosi_bits = '0; rv_data = '0;
        slave_word = sword;
        wait_ready_a();
        tx_data_a  = data;
        tx_valid_a = 1'b1;
        @(posedge clk); #1;
        tx_valid_a = 1'b0;
        check("busy_c0", 32'(busy_a), 32'd1);
        prev_sclk = s_clk_a;
        for (int cyc = 1; cyc <= 80; cyc++) begin
            if (cyc == change_cyc) tx_data_a = 8'h00;
            if (cyc == rst_cyc) reset_n = 1'b0;
            @(posedge clk); #1;
            if (!chip_sel_a) begin
                if (cs_first < 0) cs_first = cyc;
                cs_last = cyc;
            end else if (mosi_a) begin
                cs_mosi_viol++;
            end
            if (s_clk_a && !prev_sclk) begin
                n_rise++;
                if (cyc != 1 + CD_A * (2 * n_rise - 1)) rise_err++;
                mosi_bits = {mosi_bits[6:0], mosi_a};
            end
            prev_sclk = s_clk_a;
            if (rx_valid_a) begin
                rv_cnt++;
                rv_cyc  = cyc;
                rv_data = rx_data_a;
            end
            if (tx_ready_a && rdy_cyc < 0) rdy_cyc = cyc;
            if (rst_cyc > 0 && cyc == rst_cyc - 1) check("rst_pre_sclk", 32'(s_clk_a), 32'd1);
            if (rst_cyc > 0 && cyc == rst_cyc) begin
                check("rst_cs", 32'(chip_sel_a), 32'd1);
                check("rst_sclk", 32'(s_clk_a), 32'd0);
                check("rst_busy", 32'(busy_a), 32'd0);
                check("rst_ready_low", 32'(tx_ready_a), 32'd0);
                reset_n = 1'b1;
            end
            if (rst_cyc > 0 && cyc == rst_cyc + 1) check("rst_ready_after", 32'(tx_ready_a), 32'd1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cs_rise, fall2, rv2_cyc, rv_n, f_rise, l_rise, nr_b;
        logic prev_cs, prev_sclk;

        reset_n = 1'b0;
        tx_data_a = '0; tx_valid_a = 1'b0;
        tx_data_b = '0; tx_valid_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_sclk", 32'(s_clk_a), 32'd0);
        check("reset_mosi", 32'(mosi_a), 32'd0);
        check("reset_cs", 32'(chip_sel_a), 32'd1);
        check("reset_ready", 32'(tx_ready_a), 32'd0);
        check("reset_rxv", 32'(rx_valid_a), 32'd0);
        check("reset_busy", 32'(busy_a), 32'd0);
        check("reset_rxdata", 32'(rx_data_a), 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_reset", 32'(tx_ready_a), 32'd1);

        // Basic frame: A5 out, slave returns 3C.
        run_frame(8'hA5, 8'h3C, 0, 0);
        check("f1_cs_first", 32'(cs_first), 32'd1);
        check("f1_cs_last", 32'(cs_last), 32'd64);
        check("f1_rises", 32'(n_rise), 32'd8);
        check("f1_rise_timing", 32'(rise_err), 32'd0);
        check("f1_mosi", 32'(mosi_bits), 32'hA5);
        check("f1_rxv_cnt", 32'(rv_cnt), 32'd1);
        check("f1_rxv_cyc", 32'(rv_cyc), 32'd65);
        check("f1_rxdata", 32'(rv_data), 32'h3C);
        check("f1_ready_cyc", 32'(rdy_cyc), 32'd68);
        check("f1_cs_mosi", 32'(cs_mosi_viol), 32'd0);
        check("f1_rxdata_hold", 32'(rx_data_a), 32'h3C);

        // tx_data changes mid-frame: frame in flight is unaffected.
        run_frame(8'hA5, 8'hC3, 10, 0);
        check("f2_mosi", 32'(mosi_bits), 32'hA5);
        check("f2_rxdata", 32'(rv_data), 32'hC3);

        // Back-to-back FF then 00 with tx_valid held high.
        slave_word = 8'h5A;
        wait_ready_a();
        tx_data_a = 8'hFF; tx_valid_a = 1'b1;
        @(posedge clk); #1;
        tx_data_a = 8'h00;
        cs_rise = -1; fall2 = -1; rv2_cyc = -1; rv_n = 0;
        prev_cs = chip_sel_a;
        for (int cyc = 1; cyc <= 150; cyc++) begin
            @(posedge clk); #1;
            if (chip_sel_a && !prev_cs && cs_rise < 0) cs_rise = cyc;
            if (!chip_sel_a && prev_cs && cs_rise >= 0 && fall2 < 0) begin
                fall2 = cyc;
                tx_valid_a = 1'b0;
            end
            prev_cs = chip_sel_a;
            if (rx_valid_a) begin
                rv_n++;
                rv2_cyc = cyc;
                check("b2b_rxdata", 32'(rx_data_a), 32'h5A);
            end
        end
        tx_valid_a = 1'b0;
        check("b2b_cs_rise", 32'(cs_rise), 32'd65);
        check("b2b_cs_fall2", 32'(fall2), 32'd70);
        check("b2b_rxv_cnt", 32'(rv_n), 32'd2);
        check("b2b_rxv2_cyc", 32'(rv2_cyc), 32'd134);

        // Reset at cycle 30 aborts the frame with no rx_valid.
        run_frame(8'hFF, 8'hFF, 0, 30);
        check("abort_rxv_cnt", 32'(rv_cnt), 32'd0);
        check("abort_rxdata", 32'(rx_data_a), 32'd0);

`ifdef SPI_MASTER_LOOPBACK_EN
        lb_a = 1'b1;
        run_frame(8'h96, 8'h00, 0, 0);
        lb_a = 1'b0;
        check("lb_rxdata", 32'(rv_data), 32'h96);
        check("lb_mosi", 32'(mosi_bits), 32'h96);
`endif

        // 16-bit, CLK_DIV=2, miso fed from mosi.
        begin
            int guard = 0;
            while (!tx_ready_b && guard < 200) begin
                @(posedge clk); #1;
                guard++;
            end
            check("ready_timeout_b", 32'(guard < 200), 32'd1);
        end
        tx_data_b = 16'h8001; tx_valid_b = 1'b1;
        @(posedge clk); #1;
        tx_valid_b = 1'b0;
        nr_b = 0; f_rise = -1; l_rise = -1; rv_cyc = -1; rv_n = 0;
        prev_sclk = s_clk_b;
        for (int cyc = 1; cyc <= 75; cyc++) begin
            @(posedge clk); #1;
            if (s_clk_b && !prev_sclk) begin
                nr_b++;
                if (f_rise < 0) f_rise = cyc;
                l_rise = cyc;
            end
            prev_sclk = s_clk_b;
            if (rx_valid_b) begin
                rv_n++;
                rv_cyc = cyc;
                check("w16_rxdata", 32'(rx_data_b), 32'h8001);
            end
        end
        check("w16_rises", 32'(nr_b), 32'd16);
        check("w16_first_rise", 32'(f_rise), 32'd3);
        check("w16_last_rise", 32'(l_rise), 32'd63);
        check("w16_rxv_cyc", 32'(rv_cyc), 32'd65);
        check("w16_rxv_cnt", 32'(rv_n), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter DATA_W, default 8: bits per frame, MSB first; legal range 2..32.
REQ-002 SHALL have parameter CLK_DIV, default 4: s_clk half-period in clk cycles; legal range 2..255.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port tx_data, input, DATA_W: frame to transmit.
REQ-006 SHALL have port tx_valid, input, 1: tx_data is valid.
REQ-007 SHALL have port tx_ready, output, 1: block accepts a frame this cycle.
REQ-008 SHALL have port rx_data, output, DATA_W: last received frame.
REQ-009 SHALL have port rx_valid, output, 1: one-cycle pulse when rx_data updates.
REQ-010 SHALL have port busy, output, 1: high from acceptance until return to IDLE.
REQ-011 SHALL have port s_clk, output, 1: serial clock to the slave.
REQ-012 SHALL have port mosi, output, 1: master out, slave in.
REQ-013 SHALL have port miso, input, 1: master in, slave out.
REQ-014 SHALL have port chip_sel, output, 1: slave select, active-low.

Function
REQ-015 SHALL implement SPI mode 0: s_clk idles low; miso sampled on s_clk rise; mosi changes after s_clk fall.
REQ-016 SHALL use states IDLE, SHIFT, HOLD; IDLE->SHIFT on tx_valid&&tx_ready; SHIFT->HOLD after the DATA_W-th s_clk fall; HOLD->IDLE after CLK_DIV cycles.
REQ-017 SHALL drive tx_ready = 1 only in IDLE and only when reset_n is high; a frame is accepted when tx_valid && tx_ready at a clk edge (acceptance edge = cycle 0).
REQ-018 SHALL hold tx_valid-independent behaviour: tx_valid deasserting or tx_data changing after acceptance has no effect on the frame in flight.
REQ-019 SHALL drive chip_sel low and mosi = tx_data[DATA_W-1] from cycle 1.
REQ-020 SHALL toggle s_clk every CLK_DIV cycles from cycle 1: rises at 1+CLK_DIV, 1+3*CLK_DIV, ...; exactly DATA_W rising edges per frame.
REQ-021 SHALL present the next transmit bit on mosi in the same cycle s_clk falls, except after the last fall.
REQ-022 SHALL, at cycle 1+2*DATA_W*CLK_DIV, drive chip_sel high, hold s_clk low, update rx_data with the DATA_W sampled bits (first sample in the MSB) and pulse rx_valid for exactly one cycle.
REQ-023 SHALL keep chip_sel high for CLK_DIV cycles in HOLD, then assert tx_ready; back-to-back frames thus have a minimum CS-high gap of CLK_DIV cycles.
REQ-024 SHALL hold rx_data stable between rx_valid pulses; rx_valid has no backpressure.
REQ-025 SHALL drive mosi low whenever chip_sel is high.
REQ-026 SHALL drive busy = (state != IDLE).

Reset
REQ-027 SHALL, with reset_n low at a clk edge, enter IDLE; s_clk=0, mosi=0, chip_sel=1, tx_ready=0, rx_valid=0, busy=0, rx_data=0, counters cleared.
REQ-028 SHALL abort a frame in flight on reset without emitting rx_valid; tx_ready=1 on the first edge with reset_n high.

Configuration
REQ-029 SHALL, with SPI_MASTER_LOOPBACK_EN defined, add input port loopback (1 bit); when high, the sampled bit comes from internal mosi instead of miso; pad outputs unchanged.
REQ-030 SHALL, without SPI_MASTER_LOOPBACK_EN, have no loopback port and always sample miso.

Structure
REQ-031 SHALL place the state encoding (IDLE, SHIFT, HOLD) and the mode-0 edge constants in shared package spi_pkg.
REQ-032 SHALL instantiate one sub-module spi_clk_gen: CLK_DIV counter emitting single-cycle rise/fall strobes and the s_clk level, enabled only in SHIFT.

Verification
REQ-033 SHALL cover: DATA_W=8, CLK_DIV=4, tx_data=8'hA5, miso driven from a slave model returning 8'h3C -> chip_sel low cycles 1..64, 8 s_clk rises at 5,13,...,61, mosi bits 1,0,1,0,0,1,0,1, rx_valid at cycle 65 with rx_data=8'h3C.
REQ-034 SHALL cover: frames 8'hFF then 8'h00 with tx_valid held high -> second chip_sel fall exactly CLK_DIV+1 cycles after first rise; rx_valid pulses twice.
REQ-035 SHALL cover: reset_n low at cycle 30 of a frame -> next edge chip_sel=1, s_clk=0, no rx_valid, tx_ready=1 one cycle after release.
REQ-036 SHALL cover: tx_data changed from 8'hA5 to 8'h00 at cycle 10 -> mosi still serialises 8'hA5.
REQ-037 SHALL cover: SPI_MASTER_LOOPBACK_EN defined, loopback=1, tx_data=8'h96, miso tied 0 -> rx_data=8'h96.
REQ-038 SHALL cover: DATA_W=16, CLK_DIV=2, tx_data=16'h8001 -> 16 s_clk rises, rx_valid at cycle 65.
